alu_rr_arbiter: RTL

- Shares a single 16-bit four-function ALU (00 add, 01 sub, 10 and, 11 or) between two requesters, r0 and r1, using round-robin arbitration.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Operands are registered and the result is registered. Only one operation is in flight at a time.
- Sits between the processor's control/execute logic and the shared ALU instance, which is instantiated inside this block.

---
 rtl/alu_rr_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one four-function ALU between two requesters.
// Requesters r0 and r1 each present a valid/ready request channel and receive
// their result on a valid/ready response channel. Ties are broken round-robin
// against the last requester that completed. Only one operation is in flight:
// IDLE accepts, EXEC computes from registered operands, RESP holds the result.
module alu_rr_arbiter #(
  parameter int ALU_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 r0_req_valid,
  output logic                 r0_req_ready,
  input  logic [1:0]           r0_opcode,
  input  logic [ALU_WIDTH-1:0] r0_op1,
  input  logic [ALU_WIDTH-1:0] r0_op2,
  output logic                 r0_rsp_valid,
  input  logic                 r0_rsp_ready,
  output logic [ALU_WIDTH-1:0] r0_rsp_result,

  input  logic                 r1_req_valid,
  output logic                 r1_req_ready,
  input  logic [1:0]           r1_opcode,
  input  logic [ALU_WIDTH-1:0] r1_op1,
  input  logic [ALU_WIDTH-1:0] r1_op2,
  output logic                 r1_rsp_valid,
  input  logic                 r1_rsp_ready,
  output logic [ALU_WIDTH-1:0] r1_rsp_result,

  output logic                 busy,
  output logic                 owner
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t                 state_r;
  logic                   last_grant_r;
  logic                   owner_r;
  logic                   busy_r;
  logic [1:0]             opcode_r;
  logic [ALU_WIDTH-1:0]   op1_r;
  logic [ALU_WIDTH-1:0]   op2_r;
  logic [ALU_WIDTH-1:0]   result_r;
  logic                   rsp_valid0_r;
  logic                   rsp_valid1_r;

  logic                   grant_valid_s;
  logic                   grant_s;
  logic [1:0]             sel_opcode_s;
  logic [ALU_WIDTH-1:0]   sel_op1_s;
  logic [ALU_WIDTH-1:0]   sel_op2_s;
  logic [ALU_WIDTH-1:0]   alu_out_s;
  logic                   owner_rsp_ready_s;

  // Shared four-function ALU; add/sub wrap modulo 2^ALU_WIDTH, no flags.
  function automatic logic [ALU_WIDTH-1:0] alu_f(
    input logic [1:0]           opc,
    input logic [ALU_WIDTH-1:0] a,
    input logic [ALU_WIDTH-1:0] b
  );
    logic [ALU_WIDTH-1:0] r;
    case (opc)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a & b;
      2'b11:   r = a | b;
      default: r = {ALU_WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Round-robin grant decision, only meaningful while the FSM is idle.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = 1'b0;
    if (state_r == IDLE) begin
      if (r0_req_valid && r1_req_valid) begin
        grant_valid_s = 1'b1;
        grant_s       = ~last_grant_r;
      end else if (r0_req_valid) begin
        grant_valid_s = 1'b1;
        grant_s       = 1'b0;
      end else if (r1_req_valid) begin
        grant_valid_s = 1'b1;
        grant_s       = 1'b1;
      end else begin
        grant_valid_s = 1'b0;
        grant_s       = 1'b0;
      end
    end else begin
      grant_valid_s = 1'b0;
      grant_s       = 1'b0;
    end
  end

  // Steer the granted requester's operation toward the operand registers.
  always_comb begin
    sel_opcode_s = 2'b00;
    sel_op1_s    = {ALU_WIDTH{1'b0}};
    sel_op2_s    = {ALU_WIDTH{1'b0}};
    if (grant_s) begin
      sel_opcode_s = r1_opcode;
      sel_op1_s    = r1_op1;
      sel_op2_s    = r1_op2;
    end else begin
      sel_opcode_s = r0_opcode;
      sel_op1_s    = r0_op1;
      sel_op2_s    = r0_op2;
    end
  end

  // Response-channel ready of whichever requester owns the in-flight result.
  always_comb begin
    owner_rsp_ready_s = 1'b0;
    if (owner_r) begin
      owner_rsp_ready_s = r1_rsp_ready;
    end else begin
      owner_rsp_ready_s = r0_rsp_ready;
    end
  end

  // The ALU only ever sees registered operands, so requester inputs cannot
  // disturb an operation once it has been accepted.
  assign alu_out_s = alu_f(opcode_r, op1_r, op2_r);

  // Main FSM: accept in IDLE, compute in EXEC, hold result in RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      busy_r       <= 1'b0;
      opcode_r     <= 2'b00;
      op1_r        <= {ALU_WIDTH{1'b0}};
      op2_r        <= {ALU_WIDTH{1'b0}};
      result_r     <= {ALU_WIDTH{1'b0}};
      rsp_valid0_r <= 1'b0;
      rsp_valid1_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            opcode_r <= sel_opcode_s;
            op1_r    <= sel_op1_s;
            op2_r    <= sel_op2_s;
            owner_r  <= grant_s;
            busy_r   <= 1'b1;
            state_r  <= EXEC;
          end
        end
        EXEC: begin
          result_r <= alu_out_s;
          if (owner_r) begin
            rsp_valid1_r <= 1'b1;
          end else begin
            rsp_valid0_r <= 1'b1;
          end
          state_r <= RESP;
        end
        RESP: begin
          if (owner_rsp_ready_s) begin
            rsp_valid0_r <= 1'b0;
            rsp_valid1_r <= 1'b0;
            last_grant_r <= owner_r;
            busy_r       <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          rsp_valid0_r <= 1'b0;
          rsp_valid1_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  // Request readiness is combinational so a grant completes in one cycle.
  assign r0_req_ready  = grant_valid_s & ~grant_s;
  assign r1_req_ready  = grant_valid_s &  grant_s;

  // Both result buses show the shared register; rsp_valid qualifies them.
  assign r0_rsp_valid  = rsp_valid0_r;
  assign r1_rsp_valid  = rsp_valid1_r;
  assign r0_rsp_result = result_r;
  assign r1_rsp_result = result_r;

  assign busy          = busy_r;
  assign owner         = owner_r;

endmodule
